// File: rtl/key_entry_buffer_if.sv
// Keypad-side inputs and display/value outputs of the key entry buffer.
interface key_entry_buffer_if;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned KS_W  = 8;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned VAL_W = 14;

  logic [KEY_W-1:0] key_value;
  logic [KS_W-1:0]  keystrokes;
  logic [BCD_W-1:0] disp_bcd;
  logic [CNT_W-1:0] digit_cnt;
  logic [VAL_W-1:0] value;
  logic             value_valid;
  logic             busy;
  logic             err;

  modport master (
    output key_value, keystrokes,
    input  disp_bcd, digit_cnt, value, value_valid, busy, err
  );

  modport slave (
    input  key_value, keystrokes,
    output disp_bcd, digit_cnt, value, value_valid, busy, err
  );
endinterface

// File: rtl/key_entry_buffer.sv
// Collects up to four BCD keypad digits and, on enter, converts them
// serially (one digit per cycle, most significant first) to binary.
module key_entry_buffer (
  input  logic               clk,
  input  logic               reset,
  key_entry_buffer_if.slave  bus
);
  localparam int unsigned KEY_W     = 4;
  localparam int unsigned KS_W      = 8;
  localparam int unsigned BCD_W     = 16;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned VAL_W     = 14;
  localparam int unsigned ACC_EXT_W = 17;
  localparam int unsigned IDX_W     = 2;

  localparam logic [KEY_W-1:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [KEY_W-1:0] KEY_BACK      = 4'd10;
  localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'd11;
  localparam logic [KEY_W-1:0] KEY_ENTER     = 4'd12;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t state_q, state_d;

  logic [KS_W-1:0]  ks_s1_q, ks_s2_q, ks_s3_q;
  logic [KEY_W-1:0] kv_s1_q, kv_s2_q;
  logic             ev_q;
  logic [KEY_W-1:0] key_q;

  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             value_valid_q, value_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [3:0]       conv_digit;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Synchronizers, key event strobe and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks_s1_q       <= '0;
      ks_s2_q       <= '0;
      ks_s3_q       <= '0;
      kv_s1_q       <= '0;
      kv_s2_q       <= '0;
      ev_q          <= 1'b0;
      key_q         <= '0;
      disp_bcd_q    <= '0;
      digit_cnt_q   <= '0;
      value_q       <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      value_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ks_s1_q       <= bus.keystrokes;
      ks_s2_q       <= ks_s1_q;
      ks_s3_q       <= ks_s2_q;
      kv_s1_q       <= bus.key_value;
      kv_s2_q       <= kv_s1_q;
      ev_q          <= (ks_s2_q != ks_s3_q);
      key_q         <= kv_s2_q;
      disp_bcd_q    <= disp_bcd_d;
      digit_cnt_q   <= digit_cnt_d;
      value_q       <= value_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      value_valid_q <= value_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  // Digit currently being folded into the accumulator
  always_comb begin
    conv_digit = disp_bcd_q[3:0];
    case (idx_q)
      2'd0:    conv_digit = disp_bcd_q[3:0];
      2'd1:    conv_digit = disp_bcd_q[7:4];
      2'd2:    conv_digit = disp_bcd_q[11:8];
      default: conv_digit = disp_bcd_q[15:12];
    endcase
  end

  // Next state, key decode and conversion step
  always_comb begin
    state_d       = state_q;
    disp_bcd_d    = disp_bcd_q;
    digit_cnt_d   = digit_cnt_q;
    value_d       = value_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    value_valid_d = 1'b0;
    busy_d        = 1'b0;
    err_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev_q) begin
          if (key_q <= KEY_MAX_DIGIT) begin
            if (digit_cnt_q < 3'd4) begin
              disp_bcd_d  = {disp_bcd_q[11:0], key_q};
              digit_cnt_d = digit_cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (key_q)
              KEY_BACK: begin
                if (digit_cnt_q != 3'd0) begin
                  disp_bcd_d  = {4'h0, disp_bcd_q[15:4]};
                  digit_cnt_d = digit_cnt_q - 3'd1;
                end
              end
              KEY_CLEAR: begin
                disp_bcd_d  = '0;
                digit_cnt_d = '0;
              end
              KEY_ENTER: begin
                if (digit_cnt_q == 3'd0) begin
                  err_d = 1'b1;
                end else begin
                  state_d = CONV;
                  acc_d   = '0;
                  idx_d   = IDX_W'(digit_cnt_q - 3'd1);
                  busy_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end

      CONV: begin
        err_d = ev_q;
        acc_d = VAL_W'(ACC_EXT_W'(acc_q) * ACC_EXT_W'(4'd10) + ACC_EXT_W'(conv_digit));
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d       = DONE;
          value_d       = acc_d;
          value_valid_d = 1'b1;
          disp_bcd_d    = '0;
          digit_cnt_d   = '0;
        end else begin
          busy_d = 1'b1;
        end
      end

      DONE: begin
        err_d   = ev_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.disp_bcd    = disp_bcd_q;
  assign bus.digit_cnt   = digit_cnt_q;
  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;

endmodule
